// File: rtl/ascon_pt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ascon_pt_sequencer
// Purpose  : Fetches 64-bit plaintext blocks from the PT/CT memory by index.
//            Applies ASCON 10* padding to the final block and hands each
//            block to the permutation core with a valid/ready handshake.
//            Writes each returned ciphertext block back to memory, truncated
//            to the bytes that carry message data.
// Ports    : clk, RST (async, active high)
//            start/datalen        - message request and length in bytes
//            busy/done            - message in progress / end-of-message pulse
//            blk_idx/mem_rdata    - block index to memory, block read back
//            pt_block/pt_valid/pt_last/pt_ready - plaintext to the core
//            ct_block/ct_valid    - ciphertext from the core
//            CTv/ct_out           - ciphertext write strobe/data to memory
// Revision : 1.0 - initial release
// ============================================================================
module ascon_pt_sequencer #(
    parameter int unsigned MEM_LAT  = 1,
    parameter logic [7:0]  PAD_BYTE = 8'h80
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic [6:0]  datalen,
    output logic        busy,
    output logic [3:0]  blk_idx,
    input  logic [63:0] mem_rdata,
    output logic [63:0] pt_block,
    output logic        pt_valid,
    output logic        pt_last,
    input  logic        pt_ready,
    input  logic [63:0] ct_block,
    input  logic        ct_valid,
    output logic        CTv,
    output logic [63:0] ct_out,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_PRESENT = 3'd2,
        S_WAIT_CT = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Value of the latency counter on the cycle mem_rdata is valid.
    localparam logic [1:0] c_LAT_LAST = 2'(MEM_LAT - 1);

    state_t      r_state;
    logic [6:0]  r_len;
    logic [1:0]  r_lat_cnt;

    logic        w_final;
    logic [2:0]  w_rem;
    logic [63:0] w_pad_block;
    logic [63:0] w_ct_masked;

    // The final block is always index datalen[6:3]; it carries w_rem data
    // bytes (possibly zero) followed by the pad byte.
    assign w_final = (blk_idx == r_len[6:3]);
    assign w_rem   = r_len[2:0];

    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_byte
            localparam logic [2:0] c_BYTE_IDX = 3'(k);
            logic w_keep;

            // Byte 0 is the most significant byte of the block.
            assign w_keep = !w_final || (c_BYTE_IDX < w_rem);

            assign w_pad_block[63-8*k -: 8] =
                w_keep                   ? mem_rdata[63-8*k -: 8] :
                (c_BYTE_IDX == w_rem)    ? PAD_BYTE               :
                                           8'h00;

            assign w_ct_masked[63-8*k -: 8] =
                w_keep ? ct_block[63-8*k -: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_lat_cnt <= '0;
            busy      <= 1'b0;
            blk_idx   <= '0;
            pt_block  <= '0;
            pt_valid  <= 1'b0;
            pt_last   <= 1'b0;
            CTv       <= 1'b0;
            ct_out    <= '0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len     <= datalen;
                        blk_idx   <= '0;
                        r_lat_cnt <= '0;
                        busy      <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        pt_block <= w_pad_block;
                        pt_last  <= w_final;
                        pt_valid <= 1'b1;
                        r_state  <= S_PRESENT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end

                S_PRESENT: begin
                    if (pt_ready) begin
                        pt_valid <= 1'b0;
                        pt_last  <= 1'b0;
                        r_state  <= S_WAIT_CT;
                    end
                end

                S_WAIT_CT: begin
                    if (ct_valid) begin
                        if (w_final && (w_rem == 3'd0)) begin
                            // Pure padding block: nothing to write back.
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            ct_out  <= w_ct_masked;
                            CTv     <= 1'b1;
                            r_state <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    CTv <= 1'b0;
                    if (w_final) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        blk_idx   <= blk_idx + 4'd1;
                        r_lat_cnt <= '0;
                        r_state   <= S_FETCH;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascon_pt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_pt_sequencer
// Purpose  : Self-checking bench for ascon_pt_sequencer. Table of message
//            records with hand-computed final-block values, plus directed
//            reset sequences. Memory and core are simple behavioural models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_pt_sequencer;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [6:0]  datalen;
    logic        busy;
    logic [3:0]  blk_idx;
    logic [63:0] mem_rdata;
    logic [63:0] pt_block;
    logic        pt_valid;
    logic        pt_last;
    logic        pt_ready;
    logic [63:0] ct_block;
    logic        ct_valid;
    logic        CTv;
    logic [63:0] ct_out;
    logic        done;

    logic [63:0] mem [16];

    int checks = 0;
    int errors = 0;
    int ctv_total = 0;
    int done_total = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[blk_idx];

    ascon_pt_sequencer #(
        .MEM_LAT  (LAT),
        .PAD_BYTE (8'h80)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .start     (start),
        .datalen   (datalen),
        .busy      (busy),
        .blk_idx   (blk_idx),
        .mem_rdata (mem_rdata),
        .pt_block  (pt_block),
        .pt_valid  (pt_valid),
        .pt_last   (pt_last),
        .pt_ready  (pt_ready),
        .ct_block  (ct_block),
        .ct_valid  (ct_valid),
        .CTv       (CTv),
        .ct_out    (ct_out),
        .done      (done)
    );

    always @(negedge clk) begin
        if (CTv)  ctv_total  <= ctv_total + 1;
        if (done) done_total <= done_total + 1;
    end

    typedef struct {
        logic [6:0]  len;
        logic        fin_mem_en;
        logic [63:0] fin_mem;
        logic        ct_fixed_en;
        logic [63:0] ct_fixed;
        int          stall;
        logic [63:0] exp_fin_pt;
        logic [63:0] exp_fin_ct;
        int          exp_ctv;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mkv(input logic [6:0] len, input logic fin_mem_en,
                                 input logic [63:0] fin_mem, input logic ct_fixed_en,
                                 input logic [63:0] ct_fixed, input int stall,
                                 input logic [63:0] exp_fin_pt,
                                 input logic [63:0] exp_fin_ct, input int exp_ctv);
        vec_t v;
        v.len         = len;
        v.fin_mem_en  = fin_mem_en;
        v.fin_mem     = fin_mem;
        v.ct_fixed_en = ct_fixed_en;
        v.ct_fixed    = ct_fixed;
        v.stall       = stall;
        v.exp_fin_pt  = exp_fin_pt;
        v.exp_fin_ct  = exp_fin_ct;
        v.exp_ctv     = exp_ctv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = {56'hABCDBEEFCAFEDC, 4'h0, 4'(i)};
    endtask

    task automatic recover();
        RST = 1'b1; start = 1'b0; pt_ready = 1'b0; ct_valid = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
    endtask

    // Runs one complete message; entered and left at a negedge.
    task automatic run_msg(input vec_t v);
        int n, r, ctv0, done0, cyc;
        logic [63:0] exp_pt, ct;
        n = int'(v.len[6:3]) + 1;
        r = int'(v.len[2:0]);
        fill_mem();
        if (v.fin_mem_en) mem[n-1] = v.fin_mem;
        ctv0  = ctv_total;
        done0 = done_total;

        start = 1'b1; datalen = v.len;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("pt_valid_in_fetch", 64'(pt_valid), 64'd0);
        repeat (LAT) @(negedge clk);
        chk("first_pt_latency", 64'(pt_valid), 64'd1);

        for (int b = 0; b < n; b++) begin
            cyc = 0;
            while (!pt_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("pt_valid_wait[%0d]", b), 64'(pt_valid), 64'd1);
            if (!pt_valid) begin
                recover();
                return;
            end
            exp_pt = (b == n-1) ? v.exp_fin_pt : mem[b];
            chk($sformatf("blk_idx[%0d]", b), 64'(blk_idx), 64'(b));
            chk($sformatf("pt_block[%0d]", b), pt_block, exp_pt);
            chk($sformatf("pt_last[%0d]", b), 64'(pt_last), 64'(b == n-1));

            for (int s = 0; s < v.stall; s++) begin
                if (s == 1) begin
                    // Spurious start and ct_valid while presenting.
                    start = 1'b1; datalen = 7'd99;
                    ct_valid = 1'b1; ct_block = '1;
                end
                @(negedge clk);
                start = 1'b0; ct_valid = 1'b0;
                chk("stall_pt_valid", 64'(pt_valid), 64'd1);
                chk("stall_pt_block", pt_block, exp_pt);
                chk("stall_pt_last", 64'(pt_last), 64'(b == n-1));
                chk("stall_no_ctv", 64'(CTv), 64'd0);
            end

            pt_ready = 1'b1;
            @(negedge clk);
            pt_ready = 1'b0;
            chk("pt_valid_after_hs", 64'(pt_valid), 64'd0);

            ct = v.ct_fixed_en ? v.ct_fixed : (exp_pt ^ 64'hFF);
            repeat (b % 3) @(negedge clk);
            ct_block = ct; ct_valid = 1'b1;
            @(negedge clk);
            ct_valid = 1'b0; ct_block = 64'h0BAD_0BAD_0BAD_0BAD;

            if (b == n-1 && r == 0) begin
                chk("no_ctv_pad_only", 64'(CTv), 64'd0);
                chk("done_pad_only", 64'(done), 64'd1);
                chk("busy_at_done", 64'(busy), 64'd0);
            end else begin
                chk($sformatf("ctv[%0d]", b), 64'(CTv), 64'd1);
                chk($sformatf("ct_out[%0d]", b), ct_out, (b == n-1) ? v.exp_fin_ct : ct);
                @(negedge clk);
                chk("ctv_one_cycle", 64'(CTv), 64'd0);
                if (b == n-1) begin
                    chk("done", 64'(done), 64'd1);
                    chk("busy_at_done", 64'(busy), 64'd0);
                end
            end
        end

        repeat (3) @(negedge clk);
        #1;
        chk("ctv_count", 64'(ctv_total - ctv0), 64'(v.exp_ctv));
        chk("done_count", 64'(done_total - done0), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog busy=%0b blk_idx=%0d", busy, blk_idx);
        $fatal(1, "timeout");
    end

    initial begin
        int ctv0;
        vecs[0] = mkv(7'd32,  1'b0, 64'h0, 1'b0, 64'h0, 0,
                      64'h8000_0000_0000_0000, 64'h0, 4);
        vecs[1] = mkv(7'd13,  1'b1, 64'h1122_3344_5566_7788, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5,
                      64'h1122_3344_5580_0000, 64'hFFFF_FFFF_FF00_0000, 2);
        vecs[2] = mkv(7'd0,   1'b0, 64'h0, 1'b0, 64'h0, 0,
                      64'h8000_0000_0000_0000, 64'h0, 0);
        vecs[3] = mkv(7'd127, 1'b0, 64'h0, 1'b0, 64'h0, 0,
                      64'hABCD_BEEF_CAFE_DC80, 64'hABCD_BEEF_CAFE_DC00, 16);
        vecs[4] = mkv(7'd8,   1'b0, 64'h0, 1'b0, 64'h0, 0,
                      64'h8000_0000_0000_0000, 64'h0, 1);
        vecs[5] = mkv(7'd7,   1'b0, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF, 0,
                      64'hABCD_BEEF_CAFE_DC80, 64'h0123_4567_89AB_CD00, 1);
        vecs[6] = mkv(7'd1,   1'b1, 64'h5A11_2233_4455_6677, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0,
                      64'h5A80_0000_0000_0000, 64'hFF00_0000_0000_0000, 1);

        fill_mem();
        RST = 1'b1; start = 1'b0; datalen = '0;
        pt_ready = 1'b0; ct_valid = 1'b0; ct_block = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pt_valid", 64'(pt_valid), 64'd0);
        chk("rst_pt_last", 64'(pt_last), 64'd0);
        chk("rst_ctv", 64'(CTv), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_blk_idx", 64'(blk_idx), 64'd0);
        chk("rst_pt_block", pt_block, 64'd0);
        chk("rst_ct_out", ct_out, 64'd0);
        RST = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_msg(vecs[i]);

        // Asynchronous reset while waiting for ciphertext.
        fill_mem();
        mem[1] = 64'h1122_3344_5566_7788;
        ctv0 = ctv_total;
        start = 1'b1; datalen = 7'd13;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !pt_valid; c++) @(negedge clk);
        chk("rstwait_pt_valid", 64'(pt_valid), 64'd1);
        pt_ready = 1'b1;
        @(negedge clk);
        pt_ready = 1'b0;
        chk("rstwait_busy", 64'(busy), 64'd1);
        #1 RST = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_pt_valid", 64'(pt_valid), 64'd0);
        chk("arst_ctv", 64'(CTv), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_pt_block", pt_block, 64'd0);
        @(negedge clk);
        RST = 1'b0;
        // Late ciphertext and stray ready in IDLE must do nothing.
        ct_block = '1; ct_valid = 1'b1; pt_ready = 1'b1;
        @(negedge clk);
        ct_valid = 1'b0; pt_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("arst_no_ctv", 64'(ctv_total - ctv0), 64'd0);
        chk("arst_idle_busy", 64'(busy), 64'd0);
        @(negedge clk);
        run_msg(vecs[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
